// File: rtl/cfg_pkg.sv
// Shared FSM state type and width helper for the configuration-bus arbiter.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FORCE = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2w(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: first requester at or after i_ptr, wrapping to 0.
// Purely combinational; o_gnt is one-hot or zero.
module rr_arb #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic w_found;
  int   w_pos;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = PW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/cfg_bus_arb.sv
// Arbitrates N_REQ config writers onto one write bus (en pulses 1 cycle after accept).
// On fault, forces pulse-width register to 0 and blocks writes to it until fault-free for HOLD_CYCLES.
module cfg_bus_arb
  import cfg_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int PAR_MAX_VAL = 255,
  parameter int ADDR_MAX    = 4,
  parameter int ADDR_PW     = 4,
  parameter int HOLD_CYCLES = 1000,
  localparam int DW = clog2w(PAR_MAX_VAL + 1),
  localparam int AW = clog2w(ADDR_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic              fault,
  output logic              en,
  output logic [AW-1:0]     addr,
  output logic [DW-1:0]     data,
  output logic              lock
);

  localparam int PW = clog2w(N_REQ);
  localparam int HW = clog2w(HOLD_CYCLES + 1);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [HW-1:0] r_hold_cnt;
  logic          r_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  logic             w_arb_en;
  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_xfer;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_data;
  logic             w_drop;

  // Grants are suppressed in the fault cycle and while the forced write is issued.
  assign w_arb_en = !rst && (((r_state == ST_IDLE) && !fault) || (r_state == ST_LOCK));

  rr_arb #(.N(N_REQ), .PW(PW)) u_rr_arb (
    .i_req (req_valid & {N_REQ{w_arb_en}}),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_xfer     = |w_gnt;
  assign w_sel_addr = req_addr[int'(w_idx)*AW +: AW];
  assign w_sel_data = req_data[int'(w_idx)*DW +: DW];
  assign w_drop     = (r_state == ST_LOCK) && (w_sel_addr == AW'(ADDR_PW));

  assign req_ready = w_gnt;
  assign en        = r_en;
  assign addr      = r_addr;
  assign data      = r_data;
  assign lock      = !rst && (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_en       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_en <= 1'b0;
      if (w_xfer) begin
        r_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        if (!w_drop) begin
          r_en   <= 1'b1;
          r_addr <= w_sel_addr;
          r_data <= w_sel_data;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (fault) r_state <= ST_FORCE;
        end
        ST_FORCE: begin
          r_en       <= 1'b1;
          r_addr     <= AW'(ADDR_PW);
          r_data     <= '0;
          r_hold_cnt <= HW'(HOLD_CYCLES);
          r_state    <= ST_LOCK;
        end
        ST_LOCK: begin
          // Counter holds the fault-free cycles still needed, including this one.
          if (fault) begin
            r_hold_cnt <= HW'(HOLD_CYCLES);
          end else if (r_hold_cnt <= HW'(1)) begin
            r_hold_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bus_arb.sv
// Randomized scoreboard bench for cfg_bus_arb against a behavioural model of the arbitration rules.
module tb_cfg_bus_arb;

  localparam int N     = 3;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int PWA   = 4;
  localparam int HOLD  = 10;
  localparam int M_NORMAL = 0, M_FORCING = 1, M_LOCKED = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fault;
  logic            en;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic            lock;

  cfg_bus_arb #(
    .N_REQ(N), .PAR_MAX_VAL(255), .ADDR_MAX(4), .ADDR_PW(PWA), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .fault(fault),
    .en(en), .addr(addr), .data(data), .lock(lock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    bit is_rst;
    int a;
    int d;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Stimulus-side state
  bit v[N];
  int a[N];
  int d[N];
  bit last_gnt[N];

  // Reference model: pointer, mode, fault-free cycles still required
  int m_ptr = 0;
  int m_mode = M_NORMAL;
  int m_left = 0;

  task automatic model_step(input bit r, input bit f);
    int g;
    int exp_rdy;
    int exp_lock;
    g = -1;
    exp_rdy = 0;
    exp_lock = 0;
    if (!r) begin
      exp_lock = (m_mode != M_NORMAL);
      if ((m_mode == M_NORMAL && !f) || m_mode == M_LOCKED) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) exp_rdy = 1 << g;
    end
    chk("req_ready", int'(req_ready), exp_rdy);
    chk("lock", int'(lock), exp_lock);
    for (int i = 0; i < N; i++) last_gnt[i] = (g == i);

    if (r) begin
      m_ptr = 0; m_mode = M_NORMAL; m_left = 0;
      q.push_back('{stamp: cyc + 1, is_rst: 1'b1, a: 0, d: 0});
      return;
    end
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (!(m_mode == M_LOCKED && a[g] == PWA))
        q.push_back('{stamp: cyc + 1, is_rst: 1'b0, a: a[g], d: d[g]});
    end
    case (m_mode)
      M_NORMAL: if (f) m_mode = M_FORCING;
      M_FORCING: begin
        q.push_back('{stamp: cyc + 1, is_rst: 1'b0, a: PWA, d: 0});
        m_mode = M_LOCKED;
        m_left = HOLD;
      end
      default: begin
        if (f) m_left = HOLD;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_NORMAL;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit r, input bit f);
    @(negedge clk);
    rst = r;
    fault = f;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_addr[i*AW +: AW] = AW'(a[i]);
      req_data[i*DW +: DW] = DW'(d[i]);
    end
    #1;
    mon_on = 1'b1;
    model_step(r, f);
  endtask

  task automatic set_all(input bit vv);
    for (int i = 0; i < N; i++) v[i] = vv;
  endtask

  // Monitor: checks the write bus against the expected queue every cycle
  int last_a = 0;
  int last_d = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      while (q.size() > 0 && q[0].stamp < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_write at cycle %0d: got no pulse, expected addr %0d data %0d at cycle %0d",
                 cyc, q[0].a, q[0].d, q[0].stamp);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].stamp == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk(e.is_rst ? "en_after_reset" : "en_pulse", int'(en), e.is_rst ? 0 : 1);
        chk("addr", int'(addr), e.a);
        chk("data", int'(data), e.d);
        last_a = e.a;
        last_d = e.d;
      end else begin
        chk("en_idle", int'(en), 0);
        chk("addr_hold", int'(addr), last_a);
        chk("data_hold", int'(data), last_d);
      end
    end
  end

  initial begin
    rst = 1'b1; fault = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin v[i] = 0; a[i] = 0; d[i] = 0; last_gnt[i] = 0; end

    repeat (3) cycle(1, 0);

    // All three requesting for six cycles: grants rotate 0,1,2,0,1,2
    for (int i = 0; i < N; i++) begin a[i] = i; d[i] = 10 + i; end
    set_all(1);
    repeat (6) cycle(0, 0);
    set_all(0);
    cycle(0, 0);

    // Wrap from ptr=2 to requester 0
    cycle(1, 0);
    v[1] = 1; cycle(0, 0); v[1] = 0;
    v[0] = 1; a[0] = 3; d[0] = 77; cycle(0, 0); v[0] = 0;
    cycle(0, 0);

    // Fault pulse in IDLE, then forced write and lockout
    cycle(0, 1);
    cycle(0, 0);
    cycle(0, 0);
    v[1] = 1; a[1] = 4; d[1] = 200; cycle(0, 0);
    a[1] = 2; d[1] = 50; cycle(0, 0); v[1] = 0;

    // Fault re-asserts late in the hold window; ten more fault-free cycles needed
    repeat (HOLD - 6) cycle(0, 0);
    cycle(0, 1);
    repeat (HOLD + 2) cycle(0, 0);

    // Reset while locked with everyone requesting; requester 0 first after release
    cycle(0, 1);
    repeat (3) cycle(0, 0);
    for (int i = 0; i < N; i++) begin a[i] = 1; d[i] = 30 + i; end
    set_all(1);
    repeat (2) cycle(1, 0);
    cycle(0, 0);
    cycle(0, 0);
    set_all(0);
    cycle(0, 0);

    // Randomized traffic with occasional faults and resets
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !last_gnt[i])) begin
          v[i] = ($urandom_range(0, 99) < 55);
          a[i] = $urandom_range(0, 4);
          d[i] = $urandom_range(0, 255);
        end
      end
      cycle(($urandom_range(0, 999) < 4), ($urandom_range(0, 99) < 3));
    end

    set_all(0);
    repeat (4) cycle(0, 0);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_bus_arb.md
CFG_BUS_ARB -- requirements
Module: cfg_bus_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, meaning the number of write requesters (range 2..8).
REQ-002 The block SHALL have parameter PAR_MAX_VAL, default 255, meaning the maximum data value; data width DW = clog2(PAR_MAX_VAL+1).
REQ-003 The block SHALL have parameter ADDR_MAX, default 4, meaning the maximum address; address width AW = clog2(ADDR_MAX+1).
REQ-004 The block SHALL have parameter ADDR_PW, default 4, meaning the pulse-width register address subject to fault lockout.
REQ-005 The block SHALL have parameter HOLD_CYCLES, default 1000, meaning the number of consecutive fault-free cycles required to leave lockout.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset; ports: clk  in  1  clock; rst  in  1  reset.
REQ-007 The block SHALL have port req_valid  in  N_REQ  per-requester write request.
REQ-008 The block SHALL have port req_addr  in  N_REQ*AW  per-requester address, requester i in slice i.
REQ-009 The block SHALL have port req_data  in  N_REQ*DW  per-requester data, requester i in slice i.
REQ-010 The block SHALL have port req_ready  out  N_REQ  one-hot grant / accept.
REQ-011 The block SHALL have port fault  in  1  overcurrent fault, already synchronised to clk.
REQ-012 The block SHALL have ports en  out  1, addr  out  AW, and data  out  DW, forming the shared configuration write bus.
REQ-013 The block SHALL have port lock  out  1  high while in FORCE or LOCK.

Function
REQ-014 A transfer SHALL occur on requester i when req_valid[i] && req_ready[i] in the same cycle.
REQ-015 At most one req_ready bit SHALL be high per cycle; it is combinational from req_valid, the RR pointer, and state.
REQ-016 Arbitration SHALL be round-robin: the first valid requester at or after pointer ptr, wrapping N_REQ-1 -> 0; after a grant to i, ptr <= (i+1) mod N_REQ.
REQ-017 A transfer in cycle t SHALL drive en=1 with the captured addr/data in cycle t+1 only (latency 1); en SHALL be a single-cycle pulse per transfer.
REQ-018 When no transfer occurs, en SHALL be 0 and addr/data SHALL hold their last values.
REQ-019 FSM states SHALL be IDLE, FORCE, and LOCK.
REQ-020 In IDLE with fault=0, the block SHALL arbitrate normally; with fault=1, all req_ready SHALL be 0, the next state SHALL be FORCE, and ptr SHALL be unchanged.
REQ-021 In FORCE, all req_ready SHALL be 0, the block SHALL issue en=1, addr=ADDR_PW, data=0 in the next cycle, and the next state SHALL be LOCK with hold_cnt <= HOLD_CYCLES.
REQ-022 In LOCK, the block SHALL arbitrate normally, except that a granted write to ADDR_PW SHALL be accepted (ready=1, ptr advances) but dropped (en stays 0).
REQ-023 In LOCK, fault=1 SHALL reload hold_cnt to HOLD_CYCLES; fault=0 SHALL decrement hold_cnt; when hold_cnt reaches 0, the next state SHALL be IDLE.
REQ-024 hold_cnt SHALL be clog2(HOLD_CYCLES+1) bits wide and SHALL never underflow.
REQ-025 A transfer accepted in the last IDLE cycle before fault is seen SHALL still emit its en pulse; the forced write SHALL follow no earlier than the next cycle.
REQ-026 Requester inputs SHALL be ignored when req_valid is 0; a requester holding valid SHALL keep its addr/data stable until ready.

Reset
REQ-027 On rst=1 at a clk edge: state=IDLE, ptr=0, hold_cnt=0, en=0, addr=0, data=0.
REQ-028 During rst=1, req_ready SHALL be all 0 and lock SHALL be 0.
REQ-029 Reset mid-LOCK SHALL abandon lockout immediately, and no forced write SHALL be emitted afterwards unless fault is seen in IDLE.

Structure
REQ-030 The state enum (IDLE/FORCE/LOCK) and the width helper SHALL live in the shared package cfg_pkg.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arb (inputs: req, ptr; output: one-hot grant, granted index).

Verification
REQ-032 Scenario: reset, then req_valid=3'b111 held for 6 cycles -> grants 0,1,2,0,1,2; en pulses one cycle later each.
REQ-033 Scenario: ptr=2, req_valid=3'b001 -> grant 0 (wrap); ptr becomes 1.
REQ-034 Scenario: fault pulses 1 cycle in IDLE -> next cycle no ready; the cycle after, en=1, addr=4, data=0; lock=1.
REQ-035 Scenario: in LOCK, requester 1 writes addr=4/data=200 -> ready=1, en stays 0; addr=2/data=50 -> en=1, addr=2, data=50.
REQ-036 Scenario: HOLD_CYCLES=10; fault re-asserts at hold_cnt=3 -> counter reloads to 10; IDLE is reached only 10 fault-free cycles later.
REQ-037 Scenario: rst asserted in LOCK with req_valid=3'b111 -> ready=0, en=0, lock=0; after release, grant 0 first.
